// File: rtl/accel_sim_pkg.sv
// Shared constants and helpers for the DNN accelerator simulation models.
// Memory buses default to 32-bit addresses and 32-bit words with four byte lanes.
package accel_sim_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_BYTE   = 4;

  // Number of index bits needed to address a buffer of the given depth.
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/psum_bram_sim_byte_merge.sv
// Builds the word to store from the current memory word, the write data
// and the per-byte write enables.
module byte_merge #(
  parameter int NUM_BYTE = 4
) (
  input  logic [8*NUM_BYTE-1:0] old_word,
  input  logic [8*NUM_BYTE-1:0] new_word,
  input  logic [NUM_BYTE-1:0]   wren,
  output logic [8*NUM_BYTE-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NUM_BYTE; i++) begin
      if (wren[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/psum_bram_sim.sv
// Behavioural simple-dual-port block RAM: byte-enabled write port, read-first
// registered read port, and a sticky error flag for out-of-range or unknown accesses.
module psum_bram_sim #(
   parameter int    ADDR_WIDTH = accel_sim_pkg::ADDR_WIDTH,
   parameter int    DATA_WIDTH = accel_sim_pkg::DATA_WIDTH,
   parameter int    NUM_BYTE   = accel_sim_pkg::NUM_BYTE,
   parameter int    DEPTH      = 65536,
   parameter int    ADDR_LSB   = 0,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] idat,
   input  logic [NUM_BYTE-1:0]   wren,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] odat,
   output logic                  err
);

   import accel_sim_pkg::*;

   localparam int IDX_W = index_width(DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] windex;
   logic [ADDR_WIDTH-1:0] rindex;
   logic                  wInRange;
   logic                  rInRange;
   logic                  wrAny;
   logic                  wrUnknown;
   logic                  wrOk;
   logic                  wrBad;
   logic [DATA_WIDTH-1:0] oldWord;
   logic [DATA_WIDTH-1:0] mergedWord;

   // Contents exist from time zero as all-zero words; reset never touches the array.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   // The full shifted address takes part in the range check, so high bits never alias.
   always_comb begin
      windex    = waddr >> ADDR_LSB;
      rindex    = raddr >> ADDR_LSB;
      wInRange  = ({1'b0, windex} < DEPTH_LIM);
      rInRange  = ({1'b0, rindex} < DEPTH_LIM);
      wrAny     = |wren;
      wrUnknown = $isunknown(wren) || (wrAny && $isunknown(waddr));
      wrOk      = wrAny && !wrUnknown && wInRange;
      wrBad     = wrUnknown || (wrAny && !wInRange);
      oldWord   = wInRange ? mem[windex[IDX_W-1:0]] : '0;
   end

   byte_merge #(
      .NUM_BYTE (NUM_BYTE)
   ) u_byte_merge (
      .old_word (oldWord),
      .new_word (idat),
      .wren     (wren),
      .merged   (mergedWord)
   );

   // Non-blocking read and write on the same edge give read-first behaviour.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         odat <= '0;
         err  <= 1'b0;
      end else begin
         if (wrOk) mem[windex[IDX_W-1:0]] <= mergedWord;
         odat <= rInRange ? mem[rindex[IDX_W-1:0]] : '0;
         err  <= err | wrBad | !rInRange;
      end
   end

endmodule

// File: tb/tb_psum_bram_sim.sv
// Scoreboard bench for psum_bram_sim: a reference memory model predicts every
// read and the error flag; expected read data is queued and popped one cycle later.
module tb_psum_bram_sim;

  localparam int DEPTH = 65536;

  logic        clk;
  logic        rst;
  logic [31:0] waddr;
  logic [31:0] idat;
  logic [3:0]  wren;
  logic [31:0] raddr;
  logic [31:0] odat;
  logic        err;

  int check_count = 0;
  int pass_count  = 0;

  logic [31:0] model_mem [int];
  logic        model_err;
  logic [31:0] exp_q [$];

  psum_bram_sim #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_BYTE   (4),
    .DEPTH      (DEPTH),
    .ADDR_LSB   (0),
    .INIT_FILE  ("")
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .waddr (waddr),
    .idat  (idat),
    .wren  (wren),
    .raddr (raddr),
    .odat  (odat),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] idx);
    if (idx >= DEPTH) return 32'h0;
    if (model_mem.exists(int'(idx))) return model_mem[int'(idx)];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] idx, input logic [31:0] data, input logic [3:0] lanes);
    logic [31:0] word;
    word = model_read(idx);
    for (int b = 0; b < 4; b++)
      if (lanes[b]) word[8*b +: 8] = data[8*b +: 8];
    model_mem[int'(idx)] = word;
  endtask

  // One clock of traffic: predict read-first data and error, then compare after the edge.
  task automatic applyStimulus(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] we,
                               input logic [31:0] ra, input string tag);
    logic [31:0] expected;
    waddr = wa;
    idat  = wd;
    wren  = we;
    raddr = ra;
    exp_q.push_back(model_read(ra));
    if (ra >= DEPTH) model_err = 1'b1;
    if (we != 4'h0) begin
      if (wa >= DEPTH) model_err = 1'b1;
      else model_write(wa, wd, we);
    end
    @(posedge clk);
    #1;
    expected = exp_q.pop_front();
    checkOutput({tag, "/odat"}, odat, expected);
    checkOutput({tag, "/err"}, {31'b0, err}, {31'b0, model_err});
    wren = 4'h0;
  endtask

  initial begin
    rst       = 1'b0;
    waddr     = 32'd20;
    idat      = 32'h1234_5678;
    wren      = 4'hF;
    raddr     = 32'd5;
    model_err = 1'b0;

    // Reset held across edges with a write pending: nothing may be stored.
    #2;
    checkOutput("rst_odat", odat, 32'h0);
    checkOutput("rst_err", {31'b0, err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_odat", odat, 32'h0);
    wren = 4'h0;
    rst  = 1'b1;

    applyStimulus(32'd0, 32'h0, 4'h0, 32'd5, "first_read");
    applyStimulus(32'd0, 32'h0, 4'h0, 32'd20, "write_in_reset");

    applyStimulus(32'd10, 32'hDEAD_BEEF, 4'hF, 32'd0, "wr10");
    applyStimulus(32'd0, 32'h0, 4'h0, 32'd10, "rd10");

    applyStimulus(32'd3, 32'h1122_3344, 4'hF, 32'd0, "wr3");
    applyStimulus(32'd3, 32'hAABB_CCDD, 4'b0101, 32'd0, "merge3");
    applyStimulus(32'd0, 32'h0, 4'h0, 32'd3, "rd3");
    checkOutput("merge_const", odat, 32'h11BB_33DD);

    applyStimulus(32'd7, 32'h1, 4'hF, 32'd0, "wr7");
    applyStimulus(32'd7, 32'h2, 4'hF, 32'd7, "rdw7");
    applyStimulus(32'd0, 32'h0, 4'h0, 32'd7, "rd7");

    applyStimulus(32'd4464, 32'hCAFE_0001, 4'hF, 32'd0, "wr4464");
    applyStimulus(32'd70000, 32'h5555_AAAA, 4'hF, 32'd0, "wr_oor");
    applyStimulus(32'd0, 32'h0, 4'h0, 32'd4464, "rd4464");
    applyStimulus(32'd0, 32'h0, 4'h0, 32'd70000, "rd_oor");
    applyStimulus(32'd0, 32'h0, 4'h0, 32'd10, "rd10_again");

    // Reset lands between edges while a write to word 3 is being driven.
    waddr = 32'd3;
    idat  = 32'hFFFF_FFFF;
    wren  = 4'hF;
    raddr = 32'd10;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_odat", odat, 32'h0);
    checkOutput("async_rst_err", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_edge_odat", odat, 32'h0);
    wren      = 4'h0;
    rst       = 1'b1;
    model_err = 1'b0;

    applyStimulus(32'd0, 32'h0, 4'h0, 32'd3, "post_rst_rd3");
    applyStimulus(32'd0, 32'h0, 4'h0, 32'd10, "post_rst_rd10");

    if (exp_q.size() != 0)
      checkOutput("queue_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
